// File: rtl/flit_sink.sv
// NoC edge ejector: credit-gated input FIFO feeding a header/size/payload parser.
// Optional SINK_TIMEOUT_EN truncates packets that stall mid-flight.
module flit_sink #(
    parameter int FLIT_SIZE      = 32,
    parameter int BUFFER_DEPTH   = 8,
    parameter int MAX_PAYLOAD    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic [15:0]          pkt_target_o,
    output logic [31:0]          pkt_size_o,
    output logic [31:0]          pkt_sum_o,
    output logic                 pkt_err_o,
    output logic [31:0]          pkt_count_o
);
    // state     | meaning
    // S_HEADER  | waiting to pop the header flit
    // S_SIZE    | waiting to pop the payload-length flit
    // S_PAYLOAD | draining payload flits, accumulating the sum
    // S_DONE    | summary presented, waiting for pkt_ready_i

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(BUFFER_DEPTH);

    if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("flit_sink: illegal parameter values");
    end

    typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD, S_DONE} state_t;

    state_t               state;
    logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          fifo_count;
    logic [31:0]          remaining;
    logic [31:0]          head;
    logic                 push;
    logic                 pop;

    assign credit_o = !rst_i && (fifo_count != DEPTH_CNT);
    assign push     = rx_i && credit_o;
    assign pop      = (state != S_DONE) && (fifo_count != '0);
    assign head     = mem[rd_ptr][31:0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef SINK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] idle_cnt;
    logic          timeout;

    // Fires on the edge that completes TIMEOUT_CYCLES consecutive idle cycles.
    assign timeout = (idle_cnt == IDLE_LAST) && !pop;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_HEADER;
            remaining    <= '0;
            pkt_valid_o  <= 1'b0;
            pkt_target_o <= '0;
            pkt_size_o   <= '0;
            pkt_sum_o    <= '0;
            pkt_err_o    <= 1'b0;
            pkt_count_o  <= '0;
`ifdef SINK_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
`ifdef SINK_TIMEOUT_EN
            if ((state == S_SIZE || state == S_PAYLOAD) && !pop) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
`endif
            case (state)
                S_HEADER: begin
                    if (pop) begin
                        pkt_target_o <= head[15:0];
                        pkt_size_o   <= '0;
                        pkt_sum_o    <= '0;
                        pkt_err_o    <= 1'b0;
                        state        <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (pop) begin
                        pkt_size_o <= head;
                        remaining  <= head;
                        if (head == '0) begin
                            pkt_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            // Oversized packets are still drained so the stream stays framed.
                            if (head > 32'(MAX_PAYLOAD)) begin
                                pkt_err_o <= 1'b1;
                            end
                            state <= S_PAYLOAD;
                        end
                    end
`ifdef SINK_TIMEOUT_EN
                    else if (timeout) begin
                        pkt_size_o  <= '0;
                        pkt_err_o   <= 1'b1;
                        pkt_valid_o <= 1'b1;
                        state       <= S_DONE;
                    end
`endif
                end
                S_PAYLOAD: begin
                    if (pop) begin
                        pkt_sum_o <= pkt_sum_o + head;
                        remaining <= remaining - 1'b1;
                        if (remaining == 32'd1) begin
                            pkt_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
`ifdef SINK_TIMEOUT_EN
                    else if (timeout) begin
                        pkt_size_o  <= pkt_size_o - remaining;
                        pkt_err_o   <= 1'b1;
                        pkt_valid_o <= 1'b1;
                        state       <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    if (pkt_ready_i) begin
                        pkt_valid_o <= 1'b0;
                        pkt_count_o <= pkt_count_o + 1'b1;
                        state       <= S_HEADER;
                    end
                end
                default: state <= S_HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_sink.sv
// Scoreboard bench for flit_sink: directed packets, backpressure, oversize, reset, optional timeout.
module tb_flit_sink;
    localparam int BUFFER_DEPTH   = 8;
    localparam int MAX_PAYLOAD    = 1024;
    localparam int TIMEOUT_CYCLES = 4096;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        pkt_ready_i = 1'b0;
    logic        credit_o;
    logic        pkt_valid_o;
    logic [15:0] pkt_target_o;
    logic [31:0] pkt_size_o;
    logic [31:0] pkt_sum_o;
    logic        pkt_err_o;
    logic [31:0] pkt_count_o;

    flit_sink #(
        .FLIT_SIZE(32), .BUFFER_DEPTH(BUFFER_DEPTH),
        .MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .credit_o(credit_o), .data_i(data_i),
        .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i), .pkt_target_o(pkt_target_o),
        .pkt_size_o(pkt_size_o), .pkt_sum_o(pkt_sum_o), .pkt_err_o(pkt_err_o),
        .pkt_count_o(pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] target;
        logic [31:0] size;
        logic [31:0] sum;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tx_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_pkt(input logic [15:0] t, input logic [31:0] s, input logic [31:0] sm,
                              input logic e, input logic [31:0] c);
        exp_t x;
        x.target = t; x.size = s; x.sum = sm; x.err = e; x.cnt = c;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [31:0] f);
        tx_q.push_back(f);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d packets outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Flit driver: offers the queue head and retires it only when credit was present.
    initial begin : driver
        logic acc;
        forever begin
            @(negedge clk_i);
            #1;
            if (tx_q.size() != 0) begin
                rx_i   = 1'b1;
                data_i = tx_q[0];
                acc    = credit_o;
            end else begin
                rx_i = 1'b0;
                acc  = 1'b0;
            end
            @(posedge clk_i);
            if (acc) begin
                void'(tx_q.pop_front());
                acc_cnt++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (pkt_valid_o && pkt_ready_i && !rst_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pkt: target 0x%04h reported, none expected", pkt_target_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_target", {16'h0, pkt_target_o}, {16'h0, e.target});
                    check("pkt_size", pkt_size_o, e.size);
                    check("pkt_sum", pkt_sum_o, e.sum);
                    check("pkt_err", {31'h0, pkt_err_o}, {31'h0, e.err});
                    @(negedge clk_i);
                    #2;
                    check("valid_one_cycle", {31'h0, pkt_valid_o}, 32'h0);
                    check("pkt_count", pkt_count_o, e.cnt);
                end
            end
        end
    end

    initial begin : main
        int guard;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #2;
        check("rst_credit", {31'h0, credit_o}, 32'h0);
        check("rst_valid", {31'h0, pkt_valid_o}, 32'h0);
        check("rst_count", pkt_count_o, 32'h0);
        check("rst_sum", pkt_sum_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        pkt_ready_i = 1'b1;
        #2;
        check("credit_after_rst", {31'h0, credit_o}, 32'h1);

        expect_pkt(16'h0102, 3, 6, 1'b0, 1);
        send(32'h0000_0102); send(3); send(1); send(2); send(3);
        wait_drain(100, "basic");

        // Backpressure: B sits in DONE while the FIFO fills behind it.
        @(negedge clk_i);
        pkt_ready_i = 1'b0;
        acc_cnt = 0;
        expect_pkt(16'h0A0B, 2, 30, 1'b0, 2);
        expect_pkt(16'h000C, 0, 0, 1'b0, 3);
        expect_pkt(16'h000D, 4, 10, 1'b0, 4);
        expect_pkt(16'h000E, 2, 1, 1'b0, 5);
        send(32'h0000_0A0B); send(2); send(10); send(20);
        send(32'h0000_000C); send(0);
        send(32'h0000_000D); send(4); send(1); send(2); send(3); send(4);
        send(32'h0000_000E); send(2); send(32'hFFFF_FFFF); send(32'h0000_0002);
        repeat (20) @(negedge clk_i);
        #2;
        check("bp_accepted", acc_cnt, BUFFER_DEPTH + 4);
        check("bp_credit_low", {31'h0, credit_o}, 32'h0);
        check("bp_valid_held", {31'h0, pkt_valid_o}, 32'h1);
        check("bp_target_held", {16'h0, pkt_target_o}, 32'h0000_0A0B);
        @(negedge clk_i);
        pkt_ready_i = 1'b1;
        @(negedge clk_i);
        #2;
        check("credit_before_pop", {31'h0, credit_o}, 32'h0);
        @(negedge clk_i);
        #2;
        check("credit_after_pop", {31'h0, credit_o}, 32'h1);
        wait_drain(200, "backpressure");
        check("bp_total_accepted", acc_cnt, 16);

        // Oversized packet: 1025 payload flits 0..1024, sum 524800.
        expect_pkt(16'h0001, MAX_PAYLOAD + 1, 32'd524800, 1'b1, 6);
        expect_pkt(16'h0077, 1, 5, 1'b0, 7);
        send(32'h0000_0001); send(MAX_PAYLOAD + 1);
        for (int i = 0; i <= MAX_PAYLOAD; i++) send(i);
        send(32'h0000_0077); send(1); send(5);
        wait_drain(3000, "oversize");

        // Reset in the middle of a payload.
        send(32'h0000_0044); send(5); send(7); send(7);
        guard = 0;
        while (tx_q.size() != 0 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2;
        check("midrst_count", pkt_count_o, 32'h0);
        check("midrst_credit", {31'h0, credit_o}, 32'h0);
        check("midrst_valid", {31'h0, pkt_valid_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_pkt(16'h0033, 2, 32'h30, 1'b0, 1);
        send(32'h0000_0033); send(2); send(32'h10); send(32'h20);
        wait_drain(100, "after_reset");

`ifdef SINK_TIMEOUT_EN
        expect_pkt(16'h0009, 2, 3, 1'b1, 2);
        send(32'h0000_0009); send(5); send(1); send(2);
        wait_drain(TIMEOUT_CYCLES + 200, "timeout");
`endif

        repeat (5) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
